// File: rtl/pwl_func_pkg.sv
// Shared types, default geometry and the output saturation helper for the
// multi-channel piecewise-linear evaluator.
package pwl_func_pkg;

  localparam int SEG_BITS  = 4;
  localparam int FRAC_BITS = 8;
  localparam int N_SEG     = 1 << SEG_BITS;
  localparam int SPAN      = 1 << (SEG_BITS + FRAC_BITS);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic {SEL_OFFSET = 1'b0, SEL_SLOPE = 1'b1} cfg_sel_t;

  // Clip a signed value into an ow-bit signed range.
  function automatic logic signed [31:0] sat_to_out(input logic signed [31:0] v, input int ow);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_func_mc_if.sv
// Sample stream, result stream and coefficient-load bus of pwl_func_mc.
interface pwl_func_mc_if #(
  parameter int N_CH       = 4,
  parameter int IN_WIDTH   = 16,
  parameter int SEG_BITS   = 4,
  parameter int COEF_WIDTH = 18,
  parameter int OUT_WIDTH  = 16
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                  in_valid, in_ready;
  logic [CHW-1:0]        in_ch;
  logic [IN_WIDTH-1:0]   in_;
  logic                  out_valid, out_ready;
  logic [CHW-1:0]        out_ch;
  logic [OUT_WIDTH-1:0]  out;
  logic [1:0]            out_flags;
  logic                  cfg_we, cfg_ready, cfg_sel;
  logic [CHW-1:0]        cfg_ch;
  logic [SEG_BITS-1:0]   cfg_addr;
  logic [COEF_WIDTH-1:0] cfg_data;

  modport master (
    output in_valid, in_ch, in_, out_ready, cfg_we, cfg_ch, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_ch, out, out_flags, cfg_ready
  );
  modport slave (
    input  in_valid, in_ch, in_, out_ready, cfg_we, cfg_ch, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, out_ch, out, out_flags, cfg_ready
  );
endinterface

// File: rtl/pwl_coef_ram.sv
// Per-channel coefficient table: {slope, offset} words, one write port with
// per-half enables, one registered read port that holds while re is low.
module pwl_coef_ram #(
  parameter int CW = 18,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [2*CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2*CW-1:0] rdata
);
  logic [2*CW-1:0] mem [1<<AW];

  // Read samples the pre-write contents, so a same-edge write is not visible.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem[waddr][CW-1:0]    <= wdata[CW-1:0];
    if (we && be[1]) mem[waddr][2*CW-1:CW] <= wdata[2*CW-1:CW];
    if (re)          rdata <= mem[raddr];
  end
endmodule

// File: rtl/pwl_func_mc.sv
// Multi-channel piecewise-linear evaluator: segment/fraction split, per-channel
// table read, multiply-accumulate with saturation, over a 3-stage stallable pipe.
module pwl_func_mc #(
  parameter int N_CH       = 4,
  parameter int IN_WIDTH   = 16,
  parameter int SEG_BITS   = 4,
  parameter int FRAC_BITS  = 8,
  parameter int X_MIN      = -2048,
  parameter int COEF_WIDTH = 18,
  parameter int OUT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst,
  pwl_func_mc_if.slave bus
);
  import pwl_func_pkg::*;

  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int STAGES = 3;
  localparam int PW     = COEF_WIDTH + FRAC_BITS + 1;
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic signed [IN_WIDTH:0] XMIN_W = (IN_WIDTH+1)'(X_MIN);
  localparam logic signed [IN_WIDTH:0] SPAN_W = (IN_WIDTH+1)'(1 << (SEG_BITS + FRAC_BITS));

  logic [0:0]          state;
  logic [SEG_BITS-1:0] cnt;
  logic                run, init, stall, in_fire;
  logic [STAGES:1]     vld_pipe;

  assign run   = (state == ST_RUN);
  assign init  = (state == ST_INIT);
  assign stall = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready  = run & ~stall;
  assign bus.cfg_ready = run;
  assign bus.out_valid = vld_pipe[STAGES];
  assign in_fire = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (init) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
  end

  // S1: offset from X_MIN, then clamp or split into segment/fraction
  logic signed [IN_WIDTH:0] x_off;
  logic [CHW-1:0]       s1_ch, s2_ch;
  logic [SEG_BITS-1:0]  s1_seg;
  logic [FRAC_BITS-1:0] s1_frac, s2_frac;
  logic                 s1_clamp, s2_clamp;

  assign x_off = $signed({bus.in_[IN_WIDTH-1], bus.in_}) - XMIN_W;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_ch <= bus.in_ch;
      if (x_off[IN_WIDTH]) begin
        s1_seg <= '0; s1_frac <= '0; s1_clamp <= 1'b1;
      end else if (x_off >= SPAN_W) begin
        s1_seg <= '1; s1_frac <= '1; s1_clamp <= 1'b1;
      end else begin
        s1_seg   <= x_off[FRAC_BITS +: SEG_BITS];
        s1_frac  <= x_off[FRAC_BITS-1:0];
        s1_clamp <= 1'b0;
      end
      s2_ch    <= s1_ch;
      s2_frac  <= s1_frac;
      s2_clamp <= s1_clamp;
    end
  end

  // S2: all channel tables read in lockstep; INIT zeroes every entry in parallel
  logic [N_CH-1:0]                     ram_we;
  logic [1:0]                          ram_be;
  logic [SEG_BITS-1:0]                 ram_waddr;
  logic [2*COEF_WIDTH-1:0]             ram_wdata;
  logic [N_CH-1:0][2*COEF_WIDTH-1:0]   rd_data;

  assign ram_be    = init ? 2'b11 : ((cfg_sel_t'(bus.cfg_sel) == SEL_SLOPE) ? 2'b10 : 2'b01);
  assign ram_waddr = init ? cnt : bus.cfg_addr;
  assign ram_wdata = init ? '0 : {2{bus.cfg_data}};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ram_we[c] = init | (run & bus.cfg_we & (bus.cfg_ch == CHW'(c)));
    pwl_coef_ram #(.CW(COEF_WIDTH), .AW(SEG_BITS)) u_ram (
      .clk(clk), .we(ram_we[c]), .be(ram_be), .waddr(ram_waddr), .wdata(ram_wdata),
      .re(~stall), .raddr(s1_seg), .rdata(rd_data[c])
    );
  end

  // S3: floor-scaled product plus offset, clipped to the output width
  logic signed [COEF_WIDTH-1:0] s2_off, s2_slope;
  logic signed [PW-1:0]         prod;
  logic signed [COEF_WIDTH:0]   sum;
  logic signed [31:0]           clip;
  logic                         sat;

  assign s2_off   = rd_data[s2_ch][COEF_WIDTH-1:0];
  assign s2_slope = rd_data[s2_ch][2*COEF_WIDTH-1:COEF_WIDTH];
  assign prod = PW'(s2_slope) * PW'($signed({1'b0, s2_frac}));
  assign sum  = $signed({s2_off[COEF_WIDTH-1], s2_off}) + (COEF_WIDTH+1)'(prod >>> FRAC_BITS);
  assign clip = sat_to_out(32'(sum), OUT_WIDTH);
  assign sat  = (clip != 32'(sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_flags <= '0;
    end else if (!stall) begin
      bus.out       <= clip[OUT_WIDTH-1:0];
      bus.out_ch    <= s2_ch;
      bus.out_flags <= {sat, s2_clamp};
    end
  end
endmodule

// File: tb/tb_pwl_func_mc.sv
// Directed and randomized checks of pwl_func_mc against an arithmetic model
// of the segment tables with an in-order scoreboard.
module tb_pwl_func_mc;
  import pwl_func_pkg::*;

  typedef struct { int ch; int y; int fl; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwl_func_mc_if bus();
  pwl_func_mc dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0, checks = 0;
  int m_off [4][N_SEG];
  int m_slope [4][N_SEG];
  exp_t sbq[$];
  int n_acc = 0, n_out = 0;
  int last_y, last_ch, last_fl;

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic exp_t model(input int ch, input int x);
    exp_t r;
    int xo, seg, frac, prod, sh, sum, clamp, sat;
    xo = x + 2048;
    if (xo < 0) begin seg = 0; frac = 0; clamp = 1; end
    else if (xo >= SPAN) begin seg = N_SEG - 1; frac = 255; clamp = 1; end
    else begin seg = xo / 256; frac = xo % 256; clamp = 0; end
    prod = m_slope[ch][seg] * frac;
    sh = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
    sum = m_off[ch][seg] + sh;
    sat = 0;
    if (sum > 32767) begin sum = 32767; sat = 1; end
    else if (sum < -32768) begin sum = -32768; sat = 1; end
    r.ch = ch; r.y = sum; r.fl = sat * 2 + clamp;
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < N_SEG; s++) begin m_off[c][s] = 0; m_slope[c][s] = 0; end
  endtask

  // One clock: observe transfers that will happen at the coming edge.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.cfg_we && bus.cfg_ready) begin
      if (bus.cfg_sel) m_slope[bus.cfg_ch][bus.cfg_addr] = int'($signed(bus.cfg_data));
      else             m_off[bus.cfg_ch][bus.cfg_addr]   = int'($signed(bus.cfg_data));
    end
    if (bus.in_valid && bus.in_ready) begin
      sbq.push_back(model(int'(bus.in_ch), int'($signed(bus.in_))));
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_has_entry", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_ch", int'(bus.out_ch), e.ch);
        chk("out", int'($signed(bus.out)), e.y);
        chk("out_flags", int'(bus.out_flags), e.fl);
      end
      last_y = int'($signed(bus.out)); last_ch = int'(bus.out_ch); last_fl = int'(bus.out_flags);
      n_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int x);
    int a, n;
    bus.in_valid = 1'b1; bus.in_ch = 2'(ch); bus.in_ = 16'(x);
    a = n_acc; n = 0;
    while (n_acc == a && n < 100) begin tick(); n++; end
    chk("send_accepted", int'(n_acc > a), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sbq.size() > 0 || bus.out_valid) && n < 200) begin tick(); n++; end
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic cfg(input int ch, input int sel, input int addr, input int data);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_sel = sel[0];
    bus.cfg_addr = 4'(addr); bus.cfg_data = 18'(data);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!bus.in_ready && n < 40) begin n++; tick(); end
    chk("init_cycles", n, 16);
    chk("cfg_ready_run", int'(bus.cfg_ready), 1);
  endtask

  initial begin
    int a0, o0, n;
    bus.in_valid = 0; bus.in_ch = 0; bus.in_ = 0; bus.out_ready = 1;
    bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_sel = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_out_ch", int'(bus.out_ch), 0);
    chk("rst_out_flags", int'(bus.out_flags), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 0);
    rst = 1'b0;
    wait_init();

    // First sample and its latency
    send(0, 0);
    tick(); chk("lat_c2_valid", int'(bus.out_valid), 0);
    tick(); chk("lat_c3_valid", int'(bus.out_valid), 1);
    drain();
    chk("zero_out", last_y, 0); chk("zero_flags", last_fl, 0);

    // Nominal interpolation, then a write colliding with the table read
    cfg(1, 0, 9, 100); cfg(1, 1, 9, 256);
    send(1, 384); drain();
    chk("nom_out", last_y, 228); chk("nom_ch", last_ch, 1); chk("nom_flags", last_fl, 0);
    send(1, 384); cfg(1, 0, 9, 500); drain();
    chk("collide_old", last_y, 228);
    send(1, 384); drain();
    chk("collide_new", last_y, 628);

    // Clamps and saturation
    cfg(2, 1, 15, -512);
    send(2, 5000); drain();
    chk("clamp_hi_out", last_y, -510); chk("clamp_hi_flags", last_fl, 1);
    cfg(2, 0, 0, 7);
    send(2, -3000); drain();
    chk("clamp_lo_out", last_y, 7); chk("clamp_lo_flags", last_fl, 1);
    cfg(3, 0, 0, 32767); cfg(3, 1, 0, 256);
    send(3, -1793); drain();
    chk("sat_out", last_y, 32767); chk("sat_flags", last_fl, 2);

    // Backpressure: 6 samples, sink blocked for 5 cycles
    a0 = n_acc; o0 = n_out;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_ch = 2'(n_acc - a0); bus.in_ = 16'(300 * (n_acc - a0) - 1900);
      tick();
    end
    chk("bp_accepted", n_acc - a0, 3);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_out_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    n = 0;
    while (n_acc - a0 < 6 && n < 50) begin
      bus.in_ch = 2'(n_acc - a0); bus.in_ = 16'(300 * (n_acc - a0) - 1900);
      tick(); n++;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_outputs", n_out - o0, 6);

    // Random traffic with coefficient loads, sink always ready
    for (int i = 0; i < 300; i++) begin
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_ch = 2'($urandom); bus.cfg_sel = 1'($urandom);
      bus.cfg_addr = 4'($urandom); bus.cfg_data = 18'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_ch = 2'($urandom);
      bus.in_ = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6400) - 3200);
      tick();
    end
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_ch = 2'($urandom);
      bus.in_ = 16'($urandom_range(0, 6400) - 3200);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset with two samples in flight
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_ = 16'd384;
    tick(); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    sbq.delete();
    clear_model();
    rst = 1'b0;
    o0 = n_out;
    wait_init();
    chk("midrst_dropped", n_out - o0, 0);
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < N_SEG; s++) send(c, s * 256 - 2048 + 255);
    drain();
    chk("cleared_outputs", n_out - o0, 4 * N_SEG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
